// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture sequencer.
//   cap_state_t  : sequencer states (IDLE, CAPTURE, DONE)
//   ENTRIES_DEF  : default RAMqueue depth in samples
//   LOG2_DEF     : default RAMqueue address width
//   DEC_W        : width of the decimation counter
package capture_pkg;

  localparam int ENTRIES_DEF = 384;
  localparam int LOG2_DEF    = 9;
  localparam int DEC_W       = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/smpl_decimator.sv
// smpl_decimator: keeps 1 of every 2**decimator sample strobes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of the strobe counter (capture start)
//   wrt_smpl    : one-cycle sample strobe
//   decimator   : log2 of the decimation ratio
//   smpl_ok     : combinational; this strobe is accepted
module smpl_decimator
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wrt_smpl,
  input  logic [3:0] decimator,
  output logic       smpl_ok
);

  logic [DEC_W-1:0] dec_cnt_reg;
  logic [DEC_W-1:0] dec_limit;

  // decimator=15 shifts the one out of range, and the subtraction then wraps
  // to all ones, which is exactly 2**15-1.
  assign dec_limit = (DEC_W'(1) << decimator) - DEC_W'(1);
  assign smpl_ok   = wrt_smpl && (dec_cnt_reg == dec_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_reg <= '0;
    end else if (clr) begin
      dec_cnt_reg <= '0;
    end else if (wrt_smpl) begin
      dec_cnt_reg <= smpl_ok ? '0 : dec_cnt_reg + DEC_W'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer writing the RAMqueue as a circular buffer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wrt_smpl          : sample strobe from the clock generator
//   run, capture_done : TrigCfg bits from cmd_cfg (levels)
//   triggered         : latched trigger from the trigger logic
//   trig_pos          : samples to store after the trigger
//   decimator         : keep 1 of every 2**decimator strobes
//   we, waddr         : RAMqueue write port (waddr also feeds cmd_cfg)
//   armed             : enough pre-trigger samples stored
//   set_capture_done  : one-cycle pulse when the capture completes
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int LOG2    = LOG2_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  input  logic [3:0]      decimator,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            set_capture_done
);

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   ENTRIES_W = (LOG2 + 1)'(ENTRIES);

  cap_state_t      state_reg, state_next;
  logic [LOG2-1:0] waddr_reg, waddr_next;
  logic [LOG2-1:0] trig_cnt_reg, trig_cnt_next;
  logic [LOG2:0]   smpl_cnt_reg, smpl_cnt_next;
  logic            armed_reg, armed_next;
  logic            dec_clr;
  logic            smpl_ok;
  logic            done_cond;
  logic            write_ok;

  smpl_decimator u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (dec_clr),
    .wrt_smpl  (wrt_smpl),
    .decimator (decimator),
    .smpl_ok   (smpl_ok)
  );

  always_comb begin
    state_next    = state_reg;
    waddr_next    = waddr_reg;
    trig_cnt_next = trig_cnt_reg;
    smpl_cnt_next = smpl_cnt_reg;
    dec_clr       = 1'b0;
    done_cond     = 1'b0;
    write_ok      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (run && !capture_done) begin
          state_next    = CAPTURE;
          waddr_next    = '0;
          trig_cnt_next = '0;
          smpl_cnt_next = '0;
          dec_clr       = 1'b1;
        end
      end
      CAPTURE: begin
        // Abort beats completion, completion beats a write: a sample that
        // arrives on the completing cycle is dropped.
        if (!run) begin
          state_next = IDLE;
        end else if (triggered && (trig_cnt_reg == trig_pos)) begin
          done_cond  = 1'b1;
          state_next = DONE;
        end else if (smpl_ok) begin
          write_ok   = 1'b1;
          waddr_next = (waddr_reg == LAST_ADDR) ? '0 : waddr_reg + LOG2'(1);
          if (smpl_cnt_reg != ENTRIES_W) begin
            smpl_cnt_next = smpl_cnt_reg + (LOG2 + 1)'(1);
          end
          if (triggered) begin
            trig_cnt_next = trig_cnt_reg + LOG2'(1);
          end
        end
      end
      DONE: begin
        if (!capture_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Evaluated on the count that will be held next cycle so armed rises on
    // the same edge that stores the last required pre-trigger sample.
    armed_next = (state_next == CAPTURE) &&
                 ((smpl_cnt_next + {1'b0, trig_pos}) >= ENTRIES_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      waddr_reg    <= '0;
      trig_cnt_reg <= '0;
      smpl_cnt_reg <= '0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      waddr_reg    <= waddr_next;
      trig_cnt_reg <= trig_cnt_next;
      smpl_cnt_reg <= smpl_cnt_next;
      armed_reg    <= armed_next;
    end
  end

  assign we               = write_ok;
  assign set_capture_done = done_cond;
  assign waddr            = waddr_reg;
  assign armed            = armed_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: self-checking bench for capture_ctrl. A count-based model
// (writes taken, strobes seen, post-trigger writes) predicts every output each
// cycle; table-driven full captures, hand sequences and random captures drive it.
module tb_capture_ctrl;

  localparam int ENTRIES = 384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wrt_smpl, run, capture_done, triggered;
  logic [8:0] trig_pos;
  logic [3:0] decimator;
  logic       we, armed, set_capture_done;
  logic [8:0] waddr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: 0 idle, 1 capture, 2 done
  int m_state, m_writes, m_strobes, m_post;
  bit m_armed;
  int wr_seen, scd_cnt;

  capture_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wrt_smpl         (wrt_smpl),
    .run              (run),
    .capture_done     (capture_done),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .set_capture_done (set_capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_writes  = 0;
    m_strobes = 0;
    m_post    = 0;
    m_armed   = 0;
  endtask

  // Compare at the falling edge, then advance the model to the next cycle.
  task automatic tick();
    int d;
    bit cap, e_scd, e_we;
    @(negedge clk);
    if (!rst_n) model_reset();
    d     = 1 << decimator;
    cap   = (m_state == 1);
    e_scd = cap && run && triggered && (m_post == int'(trig_pos));
    e_we  = cap && run && !e_scd && wrt_smpl && ((m_strobes % d) == d - 1);
    chk("we", int'(we), int'(e_we));
    chk("set_capture_done", int'(set_capture_done), int'(e_scd));
    chk("waddr", int'(waddr), m_writes % ENTRIES);
    chk("armed", int'(armed), int'(m_armed));
    if (we) wr_seen++;
    if (set_capture_done) scd_cnt++;
    if (rst_n) begin
      case (m_state)
        0: if (run && !capture_done) begin
             m_state = 1; m_writes = 0; m_strobes = 0; m_post = 0;
           end
        1: if (!run) m_state = 0;
           else if (e_scd) m_state = 2;
           else begin
             if (e_we) begin
               m_writes++;
               if (triggered) m_post++;
             end
             if (wrt_smpl) m_strobes++;
           end
        default: if (!capture_done) m_state = 0;
      endcase
      m_armed = (m_state == 1) &&
                (((m_writes < ENTRIES) ? m_writes : ENTRIES) + int'(trig_pos) >= ENTRIES);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wrt_smpl = 0; run = 0; capture_done = 0; triggered = 0;
    trig_pos = '0; decimator = '0;
    model_reset();
    tick();
    chk("reset_waddr", int'(waddr), 0);
    chk("reset_armed", int'(armed), 0);
    rst_n = 1'b1;
  endtask

  // Host side of completion: latch capture_done, idle a while, then release.
  task automatic finish_done(input string tag);
    int w0;
    capture_done = 1'b1;
    w0 = wr_seen;
    repeat (5) tick();
    chk({tag, "_no_write_in_done"}, wr_seen, w0);
    capture_done = 1'b0; run = 1'b0; triggered = 1'b0;
    repeat (2) tick();
  endtask

  typedef struct {
    int dec;
    int tp;
    int trig_at;     // -1: raise on first armed cycle, else after N writes
    int exp_writes;
    int exp_waddr;
    int exp_arm_at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int arm_at, cyc, trig_cyc;
    bit timed_out;

    vecs[0] = '{dec: 0, tp: 10, trig_at: -1,  exp_writes: 384, exp_waddr: 0,   exp_arm_at: 374};
    vecs[1] = '{dec: 2, tp: 10, trig_at: -1,  exp_writes: 384, exp_waddr: 0,   exp_arm_at: 374};
    vecs[2] = '{dec: 0, tp: 10, trig_at: 500, exp_writes: 510, exp_waddr: 126, exp_arm_at: 374};
    vecs[3] = '{dec: 0, tp: 0,  trig_at: -1,  exp_writes: 384, exp_waddr: 0,   exp_arm_at: 384};

    do_reset();

    // ---- table-driven full captures
    for (int v = 0; v < 4; v++) begin
      decimator = 4'(vecs[v].dec); trig_pos = 9'(vecs[v].tp);
      wrt_smpl = 1; run = 1; capture_done = 0; triggered = 0;
      wr_seen = 0; scd_cnt = 0; arm_at = -1; timed_out = 1;
      for (cyc = 0; cyc < 8000; cyc++) begin
        tick();
        if (armed && arm_at < 0) arm_at = wr_seen;
        if (!triggered && ((vecs[v].trig_at < 0 && armed) ||
                           (vecs[v].trig_at >= 0 && wr_seen >= vecs[v].trig_at)))
          triggered = 1;
        if (scd_cnt > 0) begin timed_out = 0; break; end
      end
      chk($sformatf("vec%0d_timeout", v), int'(timed_out), 0);
      chk($sformatf("vec%0d_writes", v), wr_seen, vecs[v].exp_writes);
      chk($sformatf("vec%0d_final_waddr", v), int'(waddr), vecs[v].exp_waddr);
      chk($sformatf("vec%0d_armed_at", v), arm_at, vecs[v].exp_arm_at);
      finish_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_pulses", v), scd_cnt, 1);
    end

    // ---- decimation: 40 strobes at ratio 4 give 10 writes
    decimator = 4'd2; trig_pos = 9'd10; wrt_smpl = 1; run = 1;
    tick();                          // IDLE -> CAPTURE
    wr_seen = 0;
    repeat (40) tick();
    chk("dec_writes", wr_seen, 10);
    chk("dec_waddr", int'(waddr), 10);
    run = 0; tick();

    // ---- abort at waddr 57 and rearm
    decimator = 4'd0; run = 1; timed_out = 1;
    for (cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (waddr == 9'd57) begin timed_out = 0; break; end
    end
    chk("abort_reach57_timeout", int'(timed_out), 0);
    run = 0;
    tick();
    chk("abort_armed", int'(armed), 0);
    chk("abort_waddr_held", int'(waddr), 57);
    tick();                          // idle: strobes must not write
    chk("abort_waddr_idle", int'(waddr), 57);
    run = 1;
    tick();
    chk("rearm_waddr", int'(waddr), 0);
    repeat (3) tick();
    chk("rearm_advance", int'(waddr), 3);

    // ---- asynchronous reset between edges
    repeat (20) tick();
    #2 rst_n = 0;
    #1;
    chk("areset_we", int'(we), 0);
    chk("areset_waddr", int'(waddr), 0);
    chk("areset_armed", int'(armed), 0);
    chk("areset_scd", int'(set_capture_done), 0);
    model_reset();
    run = 0;
    tick();
    rst_n = 1;

    // ---- random captures against the model
    for (int r = 0; r < 6; r++) begin
      decimator = (r == 5) ? 4'd0 : 4'($urandom_range(0, 2));
      trig_pos  = (r == 5) ? 9'd400 : 9'($urandom_range(0, 60));
      trig_cyc  = $urandom_range(0, 1500);
      run = 1; capture_done = 0; triggered = 0; scd_cnt = 0; timed_out = 1;
      for (cyc = 0; cyc < 10000; cyc++) begin
        wrt_smpl = ($urandom_range(0, 3) != 0);
        if (cyc == trig_cyc) triggered = 1;
        run = ($urandom_range(0, 1999) != 0);
        tick();
        if (scd_cnt > 0) begin timed_out = 0; break; end
      end
      chk($sformatf("rand%0d_timeout", r), int'(timed_out), 0);
      wrt_smpl = 1; run = 1;
      finish_done($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
